// File: rtl/sodalite_irq_ctrl.sv
// Avalon-MM interrupt aggregator: per-source latch, mask and priority readout.
// Define IRQCTRL_SYNC_EN to pass irq_in through a 2-flop synchronizer first.
module sodalite_irq_ctrl #(
  parameter int unsigned          N_IRQ      = 4,
  parameter logic [N_IRQ-1:0]     MODE_RESET = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  input  logic [N_IRQ-1:0]  irq_in,
  output logic              irq
);

  localparam int unsigned PAD = 16 - N_IRQ;

  logic [N_IRQ-1:0] si;
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] enable;
  logic [N_IRQ-1:0] mode;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] set_v;
  logic [N_IRQ-1:0] clr_v;
  logic [N_IRQ-1:0] edge_next;
  logic [N_IRQ-1:0] pending_next;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] wdata;
  logic             wr;
  logic             active_valid;
  logic [3:0]       active_idx;
  logic [15:0]      read_val;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[15:N_IRQ];
  assign wdata        = writedata[N_IRQ-1:0];
  assign wr           = chipselect & ~write_n;

`ifdef IRQCTRL_SYNC_EN
  logic [N_IRQ-1:0] sync_q1;
  logic [N_IRQ-1:0] sync_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign si = sync_q2;
`else
  assign si = irq_in;
`endif

  assign rise   = si & ~prev;
  assign set_v  = rise | ((wr && address == 3'd5) ? wdata : '0);
  assign clr_v  = (wr && address == 3'd1) ? wdata : '0;
  // set dominates clear; level bits simply mirror the sampled input
  assign edge_next    = set_v | (pending & ~clr_v);
  assign pending_next = (mode & edge_next) | (~mode & si);
  assign masked       = pending & enable;

  always_comb begin
    active_valid = 1'b0;
    active_idx   = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (masked[i-1]) begin
        active_valid = 1'b1;
        active_idx   = 4'(i - 1);
      end
    end
  end

  always_comb begin
    read_val = '0;
    case (address)
      3'd0:    read_val = {{PAD{1'b0}}, si};
      3'd1:    read_val = {{PAD{1'b0}}, pending};
      3'd2:    read_val = {{PAD{1'b0}}, enable};
      3'd3:    read_val = {{PAD{1'b0}}, mode};
      3'd4:    read_val = {active_valid, 11'b0, active_idx};
      default: read_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      pending  <= '0;
      enable   <= '0;
      mode     <= MODE_RESET;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      prev     <= si;
      pending  <= pending_next;
      irq      <= |masked;
      readdata <= read_val;
      if (wr && address == 3'd2) enable <= wdata;
      if (wr && address == 3'd3) mode   <= wdata;
    end
  end

endmodule

// File: tb/tb_sodalite_irq_ctrl.sv
// Self-checking bench for sodalite_irq_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the register map.
module tb_sodalite_irq_ctrl;

  localparam int unsigned N  = 4;
  localparam logic [3:0]  MR = 4'h0;
`ifdef IRQCTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [3:0]  irq_in;
  logic        irq;

  int nchk;
  int nerr;

  // behavioural model state
  logic [3:0]  m_pend, m_en, m_mode, m_prev, m_s1, m_s2;
  logic        m_irq;
  logic [15:0] m_rd;

  sodalite_irq_ctrl #(.N_IRQ(N), .MODE_RESET(MR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] model_read(input logic [2:0] a, input logic [3:0] s);
    logic [15:0] r;
    r = 16'h0000;
    case (a)
      3'd0: r = {12'h000, s};
      3'd1: r = {12'h000, m_pend};
      3'd2: r = {12'h000, m_en};
      3'd3: r = {12'h000, m_mode};
      3'd4: begin
        for (int i = 3; i >= 0; i--)
          if (m_pend[i] && m_en[i]) r = 16'h8000 | 16'(i);
      end
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = MR; m_prev = '0;
    m_s1 = '0; m_s2 = '0; m_irq = 1'b0; m_rd = '0;
  endtask

  // one clock: advance the model with the inputs presented at this edge
  task automatic step();
    logic [3:0] s, np;
    logic       wr, set_b, clr_b;
    @(posedge clk);
    if (reset_n) begin
`ifdef IRQCTRL_SYNC_EN
      s = m_s2;
`else
      s = irq_in;
`endif
      m_rd = model_read(address, s);
      wr = chipselect && !write_n;
      for (int i = 0; i < 4; i++) begin
        if (m_mode[i]) begin
          set_b = (s[i] && !m_prev[i]) || (wr && address == 3'd5 && writedata[i]);
          clr_b = wr && address == 3'd1 && writedata[i];
          np[i] = set_b ? 1'b1 : (clr_b ? 1'b0 : m_pend[i]);
        end else begin
          np[i] = s[i];
        end
      end
      m_irq = |(m_pend & m_en);
      if (wr && address == 3'd2) m_en   = writedata[3:0];
      if (wr && address == 3'd3) m_mode = writedata[3:0];
      m_prev = s;
      m_s2   = m_s1;
      m_s1   = irq_in;
      m_pend = np;
    end
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a;
    step();
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    irq_in = '0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    nchk++;
    if (readdata !== 16'h0000 || irq !== 1'b0) begin
      nerr++; $display("FAIL reset_outputs: readdata=%h irq=%b, required 0000/0", readdata, irq);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a));
      exp = (a == 3) ? {12'h000, MR} : 16'h0000;
      nchk++;
      if (readdata !== exp || irq !== 1'b0) begin
        nerr++; $display("FAIL reset_read addr %0d: readdata=%h irq=%b, required %h/0", a, readdata, irq, exp);
      end
    end
  endtask

  task automatic test_level();
    logic exp_irq;
    int   highs;
    bus_write(3'd3, 16'h0000);
    bus_write(3'd2, 16'h0001);
    address = 3'd1;
    irq_in  = 4'h1;
    highs   = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) irq_in = 4'h0;
      step();
      exp_irq = (k >= LAT) && (k < LAT + 3);
      if (irq === 1'b1) highs++;
      nchk++;
      if (irq !== exp_irq || readdata !== m_rd) begin
        nerr++; $display("FAIL level_cycle %0d: irq=%b pending=%h, required %b/%h", k, irq, readdata, exp_irq, m_rd);
      end
    end
    nchk++;
    if (highs != 3) begin
      nerr++; $display("FAIL level_irq_len: %0d cycles high, required 3", highs);
    end
  endtask

  task automatic test_edge_active();
    irq_in = 4'h0;
    bus_write(3'd3, 16'h000F);
    bus_write(3'd2, 16'h0004);
    bus_write(3'd1, 16'h000F);
    irq_in = 4'h4; step();
    irq_in = 4'h2; step();
    irq_in = 4'h0;
    repeat (4) step();
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h0006 || irq !== 1'b1) begin
      nerr++; $display("FAIL edge_pending: pending=%h irq=%b, required 0006/1", readdata, irq);
    end
    bus_read(3'd4);
    nchk++;
    if (readdata !== 16'h8002) begin
      nerr++; $display("FAIL edge_active: got %h, required 8002", readdata);
    end
    bus_write(3'd1, 16'h0004);
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h0002 || irq !== 1'b0) begin
      nerr++; $display("FAIL w1c_pending: pending=%h irq=%b, required 0002/0", readdata, irq);
    end
    bus_read(3'd4);
    nchk++;
    if (readdata !== 16'h0000) begin
      nerr++; $display("FAIL w1c_active: got %h, required 0000", readdata);
    end
  endtask

  task automatic test_set_wins();
    irq_in = 4'h8;
    repeat (LAT - 1) step();
    bus_write(3'd1, 16'h0008);
    irq_in = 4'h0;
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h000A) begin
      nerr++; $display("FAIL set_wins: pending=%h, required 000A", readdata);
    end
    repeat (3) step();
    bus_write(3'd1, 16'h0008);
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h0002) begin
      nerr++; $display("FAIL w1c_only: pending=%h, required 0002", readdata);
    end
  endtask

  task automatic test_force();
    bus_write(3'd1, 16'h000F);
    bus_write(3'd5, 16'h0001);
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h0001) begin
      nerr++; $display("FAIL force_edge: pending=%h, required 0001", readdata);
    end
    bus_read(3'd5);
    nchk++;
    if (readdata !== 16'h0000) begin
      nerr++; $display("FAIL force_read: got %h, required 0000", readdata);
    end
    bus_write(3'd3, 16'h000E);
    step();
    bus_write(3'd5, 16'h0001);
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h0000) begin
      nerr++; $display("FAIL force_level: pending=%h, required 0000", readdata);
    end
    bus_write(3'd2, 16'hFFFF);
    bus_read(3'd2);
    nchk++;
    if (readdata !== 16'h000F) begin
      nerr++; $display("FAIL enable_width: got %h, required 000F", readdata);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      irq_in     = 4'($urandom);
      address    = 3'($urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = 16'($urandom);
      step();
      nchk++;
      if (readdata !== m_rd || irq !== m_irq) begin
        nerr++; $display("FAIL random %0d: readdata=%h irq=%b, required %h/%b", n, readdata, irq, m_rd, m_irq);
      end
    end
    chipselect = 1'b0; write_n = 1'b1; irq_in = 4'h0;
  endtask

  task automatic test_async_reset();
    bus_write(3'd3, 16'h000F);
    bus_write(3'd2, 16'h000F);
    bus_write(3'd5, 16'h000F);
    repeat (2) step();
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h000F || irq !== 1'b1) begin
      nerr++; $display("FAIL pre_reset: pending=%h irq=%b, required 000F/1", readdata, irq);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    nchk++;
    if (readdata !== 16'h0000 || irq !== 1'b0) begin
      nerr++; $display("FAIL async_reset: readdata=%h irq=%b, required 0000/0", readdata, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd1);
    bus_read(3'd1);
    nchk++;
    if (readdata !== 16'h0000 || irq !== 1'b0) begin
      nerr++; $display("FAIL post_reset: pending=%h irq=%b, required 0000/0", readdata, irq);
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    reset_n = 1'b1;
    test_reset();
    test_level();
    test_edge_active();
    test_set_wins();
    test_force();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
